// File: rtl/seq_signed_multiplier.sv
// Multi-cycle two's-complement multiplier built on radix-2 Booth recoding.
// Takes one operand pair per in_valid/in_ready handshake. It performs one
// Booth add/subtract-and-shift step per clock for WIDTH clocks, then holds
// the full 2*WIDTH-bit product until the consumer takes it with out_ready.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operand pair presented (a, b)
//   in_ready  block can accept operands (IDLE only)
//   a, b      signed multiplicand / multiplier, WIDTH bits
//   out_valid product valid (DONE only)
//   out_ready consumer accepts product
//   product   signed a*b, 2*WIDTH bits, held until the next result or reset
//   overflow  product does not fit in a WIDTH-bit signed value
//   busy      high in CALC or DONE
module seq_signed_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] product,
  output logic                      overflow,
  output logic                      busy
);

  localparam int PW = 2*WIDTH + 2;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state, state_nxt;
  logic signed [WIDTH:0]   m;
  logic signed [PW-1:0]    p, p_step;
  logic [CW-1:0]           cnt;
  logic                    last_step;

  // One Booth step: conditional add/subtract of the multiplicand into the
  // upper WIDTH+1 bits, then an arithmetic shift of the whole accumulator.
  // The extra top bit keeps M = -2^(WIDTH-1) from wrapping.
  function automatic logic signed [PW-1:0] booth_step(
    input logic signed [PW-1:0] acc,
    input logic signed [WIDTH:0] mc
  );
    logic signed [WIDTH:0] hi;
    hi = acc[PW-1:WIDTH+1];
    unique case (acc[1:0])
      2'b01:   hi = hi + mc;
      2'b10:   hi = hi - mc;
      default: hi = hi;
    endcase
    return $signed({hi, acc[WIDTH:0]}) >>> 1;
  endfunction

  // The narrow result fits iff the top WIDTH+1 product bits are a pure sign run.
  function automatic logic narrow_overflow(input logic [2*WIDTH-1:0] prod);
    logic [WIDTH:0] top;
    top = prod[2*WIDTH-1:WIDTH-1];
    return !((&top) || (~|top));
  endfunction

  assign p_step    = booth_step(p, m);
  assign last_step = (cnt == CW'(WIDTH-1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m        <= '0;
      p        <= '0;
      cnt      <= '0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        // accept: load multiplicand and seed accumulator with b and Booth bit 0
        IDLE: begin
          if (in_valid) begin
            m   <= {a[WIDTH-1], a};
            p   <= {{(WIDTH+1){1'b0}}, b, 1'b0};
            cnt <= '0;
          end
        end
        // iterate: one recoded digit per clock, result registered on the last
        CALC: begin
          p   <= p_step;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            product  <= p_step[2*WIDTH:1];
            overflow <= narrow_overflow(p_step[2*WIDTH:1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
